truth_table_sweeper: RTL and testbench

- Sequential sweep engine for 4-input combinational exercise blocks: drives every input vector 0..2^N_IN-1 into the combinational block under test and captures its single-bit output Y per vector.
- Sits directly around the combinational stage. It feeds its inputs (vec_out[N_IN-1] = A ... vec_out[0] = D) and consumes its output (y_in).
- Produces a packed truth table plus a count of ones, so the exercise can be checked in hardware rather than by a bench that only prints values.

---
 rtl/truth_table_sweeper_if.sv | 31 +++
 rtl/truth_table_sweeper.sv | 132 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// ============================================================================
// Module   : truth_table_sweeper_if
// Brief    : Control/result bundle between a sweep controller and the sweeper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic                   start;
  logic                   abort;
  logic                   y_in;
  logic [N_IN-1:0]        vec_out;
  logic                   busy;
  logic                   done;
  logic [(1<<N_IN)-1:0]   truth_table;
  logic [N_IN:0]          ones_count;

  modport master (
    output start, abort, y_in,
    input  vec_out, busy, done, truth_table, ones_count
  );

  modport slave (
    input  start, abort, y_in,
    output vec_out, busy, done, truth_table, ones_count
  );
endinterface

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// Module   : truth_table_sweeper
// Brief    : Drives every input vector into a combinational block and records
//            its output as a packed truth table plus a count of ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  wire                          clk,
  input  wire                          rst_n,
  truth_table_sweeper_if.slave         bus
);

  localparam int                c_TT_W        = 1 << N_IN;
  localparam bit                c_ZERO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [3:0]        c_SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]   c_VEC_LAST    = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic [N_IN-1:0]     r_vec;
  logic [N_IN-1:0]     w_vec_next;
  logic [c_TT_W-1:0]   r_tt;
  logic [c_TT_W-1:0]   w_tt_next;
  logic [N_IN:0]       r_ones;
  logic [N_IN:0]       w_ones_next;
  logic                r_busy;
  logic                r_done;
  logic                w_busy_next;
  logic                w_done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_tt    <= '0;
      r_ones  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_vec   <= w_vec_next;
      r_tt    <= w_tt_next;
      r_ones  <= w_ones_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_vec_next   = r_vec;
    w_tt_next    = r_tt;
    w_ones_next  = r_ones;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_tt_next    = '0;
          w_ones_next  = '0;
          w_vec_next   = '0;
          w_cnt_next   = '0;
          w_state_next = c_ZERO_SETTLE ? SAMPLE : SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          w_state_next = IDLE;
          w_vec_next   = '0;
          w_cnt_next   = '0;
        end else if (r_cnt == c_SETTLE_LAST) begin
          w_cnt_next   = '0;
          w_state_next = SAMPLE;
        end else begin
          w_cnt_next   = r_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        // Abort beats the sample: nothing from this cycle is recorded.
        if (bus.abort) begin
          w_state_next = IDLE;
          w_vec_next   = '0;
          w_cnt_next   = '0;
        end else begin
          w_tt_next[r_vec] = bus.y_in;
          w_ones_next      = r_ones + {{N_IN{1'b0}}, bus.y_in};
          if (r_vec == c_VEC_LAST) begin
            w_state_next = DONE;
          end else begin
            w_vec_next   = r_vec + 1'b1;
            w_state_next = c_ZERO_SETTLE ? SAMPLE : SETTLE;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they leave a flop.
  assign w_busy_next = (w_state_next == SETTLE) || (w_state_next == SAMPLE);
  assign w_done_next = (w_state_next == DONE);

  assign bus.vec_out     = r_vec;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.truth_table = r_tt;
  assign bus.ones_count  = r_ones;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE_CYCLES 2 and 0) share
// stimulus and are compared every cycle against a sweep-timeline model.
`default_nettype none

module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] func = 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(4)) bus0 ();
  truth_table_sweeper_if #(.N_IN(4)) bus1 ();

  assign bus0.start = start;
  assign bus0.abort = abort;
  assign bus0.y_in  = func[bus0.vec_out];
  assign bus1.start = start;
  assign bus1.abort = abort;
  assign bus1.y_in  = func[bus1.vec_out];

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Model: t = 0 idle, 1..16*L busy cycle index within the sweep, 16*L+1 done.
  typedef struct packed {
    logic [31:0] t;
    logic [3:0]  vec;
    logic [15:0] tt;
    logic [4:0]  cnt;
  } mstate_t;

  function automatic mstate_t mstep(mstate_t s, logic st, logic ab, logic [15:0] f, int L);
    mstate_t n;
    int      T;
    int      v;
    n = s;
    T = 16 * L;
    if (s.t == 0) begin
      if (st) begin
        n.t = 1; n.tt = '0; n.cnt = '0; n.vec = '0;
      end
    end else if (s.t <= T) begin
      if (ab) begin
        n.t = 0; n.vec = '0;
      end else begin
        if ((s.t % L) == 0) begin
          v = int'(s.t) / L - 1;
          n.tt[v] = f[v];
          n.cnt   = s.cnt + {4'b0, f[v]};
        end
        n.t = s.t + 1;
        if (n.t <= T) n.vec = 4'((int'(n.t) - 1) / L);
      end
    end else begin
      n.t = 0;
    end
    return n;
  endfunction

  function automatic logic [26:0] expp(mstate_t s, int L);
    int T;
    T = 16 * L;
    return {(s.t >= 1 && s.t <= T), (s.t == T + 1), s.vec, s.tt, s.cnt};
  endfunction

  mstate_t m0 = '0;
  mstate_t m1 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mstep(m0, start, abort, func, 3);
      m1 <= mstep(m1, start, abort, func, 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  // Per-cycle model comparison at the falling edge, then return to the
  // drive point just after the next rising edge.
  task automatic step();
    @(negedge clk);
    check("cmp0", {bus0.busy, bus0.done, bus0.vec_out, bus0.truth_table, bus0.ones_count}, expp(m0, 3));
    check("cmp1", {bus1.busy, bus1.done, bus1.vec_out, bus1.truth_table, bus1.ones_count}, expp(m1, 1));
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Pulse start for one cycle and report the cycle in which each done fires.
  task automatic run_sweep(input logic [15:0] f, input logic [15:0] prev_tt, output int d0, output int d1);
    func  = f;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_rise", {31'b0, bus0.busy}, 32'd1);
    check("tt_cleared", {16'b0, bus0.truth_table}, 32'd0);
    if (prev_tt != 16'h0) check("tt_clr_vs_prev", {31'b0, (bus0.truth_table == prev_tt)}, 32'd0);
    d0 = -1;
    d1 = -1;
    for (int c = 1; c <= 80; c++) begin
      if (bus0.done && d0 < 0) d0 = c;
      if (bus1.done && d1 < 0) d1 = c;
      if (d0 >= 0) break;
      step();
    end
    if (d0 < 0) check("done_timeout", 32'hFFFF_FFFF, 32'd49);
  endtask

  int d0, d1;
  logic [3:0] prev_vec;
  logic       mono_ok;
  logic       saw_done;

  initial begin
    #1;
    check("rst0", {bus0.busy, bus0.done, bus0.vec_out, bus0.truth_table, bus0.ones_count}, 32'd0);
    check("rst1", {bus1.busy, bus1.done, bus1.vec_out, bus1.truth_table, bus1.ones_count}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(3);

    // Y = D
    run_sweep(16'hAAAA, 16'h0, d0, d1);
    check("done_cycle_s2", d0, 32'd49);
    check("done_cycle_s0", d1, 32'd17);
    check("tt_D", {16'b0, bus0.truth_table}, 32'h0000AAAA);
    check("ones_D", {27'b0, bus0.ones_count}, 32'd8);
    check("model_tt_D", {16'b0, m0.tt}, 32'h0000AAAA);
    check("tt_D_s0", {16'b0, bus1.truth_table}, 32'h0000AAAA);
    idle(5);
    check("hold_tt", {16'b0, bus0.truth_table}, 32'h0000AAAA);

    // Y = A&B
    run_sweep(16'hF000, 16'hAAAA, d0, d1);
    check("tt_AB", {16'b0, bus0.truth_table}, 32'h0000F000);
    check("ones_AB", {27'b0, bus0.ones_count}, 32'd4);
    idle(3);

    // Y = 1
    run_sweep(16'hFFFF, 16'hF000, d0, d1);
    check("tt_one", {16'b0, bus0.truth_table}, 32'h0000FFFF);
    check("ones_one", {27'b0, bus0.ones_count}, 32'd16);
    check("model_ones_one", {27'b0, m0.cnt}, 32'd16);
    idle(3);

    // start held across a whole sweep
    func     = 16'h3C5A;
    start    = 1'b1;
    mono_ok  = 1'b1;
    prev_vec = 4'd0;
    d0       = -1;
    step();
    for (int c = 1; c <= 80; c++) begin
      if (bus0.vec_out < prev_vec) mono_ok = 1'b0;
      prev_vec = bus0.vec_out;
      if (bus0.done) begin d0 = c; break; end
      step();
    end
    check("held_done_cycle", d0, 32'd49);
    check("held_monotonic", {31'b0, mono_ok}, 32'd1);
    check("held_tt", {16'b0, bus0.truth_table}, 32'h00003C5A);
    step();
    check("held_idle", {31'b0, bus0.busy}, 32'd0);
    step();
    check("held_restart_busy", {31'b0, bus0.busy}, 32'd1);
    check("held_restart_tt", {16'b0, bus0.truth_table}, 32'd0);
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    idle(20);

    // abort after five vectors sampled; the S=0 instance is in its last sample
    func  = 16'hAAAA;
    start = 1'b1;
    step();
    start = 1'b0;
    idle(15);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", {31'b0, bus0.busy}, 32'd0);
    check("abort_vec", {28'b0, bus0.vec_out}, 32'd0);
    check("abort_tt", {16'b0, bus0.truth_table}, 32'h0000000A);
    check("abort_ones", {27'b0, bus0.ones_count}, 32'd2);
    check("abort_last_tt", {16'b0, bus1.truth_table}, 32'h00002AAA);
    check("abort_last_ones", {27'b0, bus1.ones_count}, 32'd7);
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus0.done || bus1.done) saw_done = 1'b1;
      step();
    end
    check("abort_no_done", {31'b0, saw_done}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 63) == 0) func = 16'($urandom);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    idle(60);

    // asynchronous reset mid-sweep
    func  = 16'h6996;
    start = 1'b1;
    step();
    start = 1'b0;
    idle(20);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst0", {bus0.busy, bus0.done, bus0.vec_out, bus0.truth_table, bus0.ones_count}, 32'd0);
    check("arst1", {bus1.busy, bus1.done, bus1.vec_out, bus1.truth_table, bus1.ones_count}, 32'd0);
    step();
    rst_n = 1'b1;
    idle(2);
    run_sweep(16'h6996, 16'h0, d0, d1);
    check("post_rst_done", d0, 32'd49);
    check("post_rst_tt", {16'b0, bus0.truth_table}, 32'h00006996);
    check("post_rst_ones", {27'b0, bus0.ones_count}, 32'd8);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
